vga_sync_gen: RTL

Parametrised VGA raster engine for the Game of Life display path. It replaces the fixed 640x480 timing inside `vga_top` with these elements:
- a configurable pixel-clock divider;
- configurable horizontal and vertical timing;
- a cell-grid read port toward the generation memory;
- a latency-matched RGB/sync output stage.

It sits between the board clock and the VGA connector. The Life engine uses its `vblank` and `frame_start` outputs to schedule generation updates.

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_sync_gen_if.sv | 31 +++
 rtl/vga_delay_line.sv | 36 +++
 rtl/vga_sync_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster engine: default 640x480@60 timing,
// frame-size helpers and the 12-bit {r,g,b} colour type.
package vga_pkg;

  // Default timing: 640x480@60 with a 25 MHz pixel rate from a 50 MHz board clock.
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_CELL_SHIFT = 4;
  localparam int DEF_RD_LAT     = 1;

  typedef logic [11:0] rgb_t;

  localparam rgb_t RGB_BLANK = 12'h000;
  localparam rgb_t RGB_ALIVE = 12'hFFF;
  localparam rgb_t RGB_DEAD  = 12'h000;
  localparam rgb_t RGB_GRID  = 12'h333;

  // Stage-0 decode carried down the delay line; sync bits are logical
  // "asserted" flags, the pin polarity is applied only at the output register.
  typedef struct packed {
    logic active;
    logic grid;
    logic hsync;
    logic vsync;
  } decode_t;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width wide enough for the larger of the two totals.
  function automatic int cnt_width(int htot, int vtot);
    int biggest;
    biggest = (htot > vtot) ? htot : vtot;
    return (biggest > 1) ? $clog2(biggest) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Display-side bundle of the raster engine: cell-grid read port toward the
// generation memory, scheduling strobes for the Life engine and VGA pins.
interface vga_sync_gen_if;

  logic [9:0] cell_x;
  logic [9:0] cell_y;
  logic       cell_alive;
  logic       pix_en;
  logic       frame_start;
  logic       vblank;
  logic       hsync_vga;
  logic       vsync_vga;
  logic [3:0] r_vga;
  logic [3:0] g_vga;
  logic [3:0] b_vga;

  // The raster engine drives the bundle.
  modport master (
    output cell_x, cell_y, pix_en, frame_start, vblank,
    output hsync_vga, vsync_vga, r_vga, g_vga, b_vga,
    input  cell_alive
  );

  // Generation memory, Life engine and connector side.
  modport slave (
    input  cell_x, cell_y, pix_en, frame_start, vblank,
    input  hsync_vga, vsync_vga, r_vga, g_vga, b_vga,
    output cell_alive
  );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align stage-0 decode with the
// memory read latency. DEPTH 0 collapses to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one position per enable; stage 0 takes the new value.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its neighbour's pre-edge value. The array is only a few
      // flops deep and must power up as "blanking", so it is reset like any
      // other register rather than left uninitialised like a RAM.
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA raster engine: pixel-clock divider, h/v counters, stage-0
// decode, latency-matched delay line and registered RGB/sync outputs.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV    = DEF_CLK_DIV,
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   CELL_SHIFT = DEF_CELL_SHIFT,
  parameter int   RD_LAT     = DEF_RD_LAT,
  parameter rgb_t ALIVE_RGB  = RGB_ALIVE,
  parameter rgb_t DEAD_RGB   = RGB_DEAD,
  parameter rgb_t GRID_RGB   = RGB_GRID,
  parameter bit   GRID_EN    = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CNT_W   = cnt_width(H_TOTAL, V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Inclusive upper bounds keep every constant representable in CNT_W bits.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] CELL_MASK  = CNT_W'((1 << CELL_SHIFT) - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] cell_x_full;
  logic [CNT_W-1:0] cell_y_full;
  decode_t          dec_s0;
  decode_t          dec_dly;
  rgb_t             rgb_next;
  rgb_t             rgb_q;
  logic             hsync_q;
  logic             vsync_q;

  // Board-clock divider producing one pixel slot every CLK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  // Gated by rst_n so the strobe is low during reset even when CLK_DIV is 1
  // (the divider match is then permanently true).
  assign pix_en = rst_n && (div_cnt == DIV_LAST);

  // Raster position: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Stage-0 decode of the raster position.
  always_comb begin
    // NOTE: every field gets a default before any condition so the block
    // stays purely combinational and never infers a latch.
    dec_s0        = '0;
    dec_s0.active = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
    dec_s0.hsync  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    dec_s0.vsync  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    dec_s0.grid   = GRID_EN && (((h_cnt & CELL_MASK) == '0) ||
                                ((v_cnt & CELL_MASK) == '0));
  end

  // Hold decode for as many pixel slots as the memory takes to answer.
  vga_delay_line #(
    .WIDTH ($bits(decode_t)),
    .DEPTH (RD_LAT)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .d     (dec_s0),
    .q     (dec_dly)
  );

  // Colour priority: blanking, then grid lines, then cell state.
  always_comb begin
    rgb_next = RGB_BLANK;
    if (!dec_dly.active)     rgb_next = RGB_BLANK;
    else if (dec_dly.grid)   rgb_next = GRID_RGB;
    else if (bus.cell_alive) rgb_next = ALIVE_RGB;
    else                     rgb_next = DEAD_RGB;
  end

  // Output register: colour and sync share one stage so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= RGB_BLANK;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else if (pix_en) begin
      rgb_q   <= rgb_next;
      hsync_q <= dec_dly.hsync ? SYNC_POL : ~SYNC_POL;
      vsync_q <= dec_dly.vsync ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign cell_x_full = h_cnt >> CELL_SHIFT;
  assign cell_y_full = v_cnt >> CELL_SHIFT;

  assign bus.cell_x      = 10'(cell_x_full);
  assign bus.cell_y      = 10'(cell_y_full);
  assign bus.pix_en      = pix_en;
  assign bus.frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
  assign bus.vblank      = !(v_cnt <= V_ACT_LAST);
  assign bus.hsync_vga   = hsync_q;
  assign bus.vsync_vga   = vsync_q;
  assign bus.r_vga       = rgb_q[11:8];
  assign bus.g_vga       = rgb_q[7:4];
  assign bus.b_vga       = rgb_q[3:0];

endmodule
